// File: rtl/multi_rate_clk_gen.sv
// Multi-channel programmable clock divider: each channel produces a divided square-wave
// (or pulse) clock and a one-cycle period tick; divisor/mode changes land on a period boundary.
module multi_rate_clk_gen #(
    parameter int CLK_HZ = 50000000,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26,
    parameter int CH_W   = 2
) (
    input  logic              clk_fiftymhz,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic              cfg_ack,
    output logic              cfg_err,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_clr,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CH_W:0]    LP_NUM_CH = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_ZERO   = CNT_W'(0);

    logic [CNT_W-1:0]  r_div     [NUM_CH];
    logic [CNT_W-1:0]  r_pdiv    [NUM_CH];
    logic [CNT_W-1:0]  r_cnt     [NUM_CH];
    logic [NUM_CH-1:0] r_mode;
    logic [NUM_CH-1:0] r_pmode;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_clk_out;
    logic [NUM_CH-1:0] r_tick;
    logic              r_cfg_ack;
    logic              r_cfg_err;

    logic              w_cfg_ok;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] w_apply;
    logic [CNT_W-1:0]  w_half_m1 [NUM_CH];
    logic [CNT_W-1:0]  w_div_nx  [NUM_CH];
    logic [CNT_W-1:0]  w_pdiv_nx [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_nx  [NUM_CH];
    logic [NUM_CH-1:0] w_mode_nx;
    logic [NUM_CH-1:0] w_pmode_nx;
    logic [NUM_CH-1:0] w_pend_nx;
    logic [NUM_CH-1:0] w_clk_nx;
    logic [NUM_CH-1:0] w_tick_nx;

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign cfg_ack = r_cfg_ack;
    assign cfg_err = r_cfg_err;

    // Per-channel next-state: config capture, pending apply, counter, clock and tick.
    always_comb begin
        w_cfg_ok = cfg_we && (cfg_div != LP_ZERO) && ({1'b0, cfg_ch} < LP_NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i]       = w_cfg_ok && (cfg_ch == CH_W'(i));
            w_wrap[i]     = ch_en[i] && (r_cnt[i] == (r_div[i] - LP_ONE));
            w_apply[i]    = r_pend[i] && (sync_clr || !ch_en[i] || w_wrap[i]);
            // ceil(D/2)-1 without forming D+1, which could overflow at full width
            w_half_m1[i]  = (r_div[i] >> 1) + CNT_W'(r_div[i][0]) - LP_ONE;
            w_div_nx[i]   = w_apply[i] ? r_pdiv[i] : r_div[i];
            w_mode_nx[i]  = w_apply[i] ? r_pmode[i] : r_mode[i];
            w_pend_nx[i]  = w_wr[i] || (r_pend[i] && !w_apply[i]);
            w_pdiv_nx[i]  = w_wr[i] ? cfg_div : r_pdiv[i];
            w_pmode_nx[i] = w_wr[i] ? cfg_mode : r_pmode[i];
            w_cnt_nx[i]   = LP_ZERO;
            w_tick_nx[i]  = 1'b0;
            w_clk_nx[i]   = !w_mode_nx[i];
            if (sync_clr || !ch_en[i]) begin
                w_cnt_nx[i]  = LP_ZERO;
                w_tick_nx[i] = 1'b0;
                w_clk_nx[i]  = !w_mode_nx[i];
            end else if (w_wrap[i]) begin
                w_cnt_nx[i]  = LP_ZERO;
                w_tick_nx[i] = 1'b1;
                w_clk_nx[i]  = 1'b1;
            end else begin
                w_cnt_nx[i]  = r_cnt[i] + LP_ONE;
                w_tick_nx[i] = 1'b0;
                if (r_mode[i]) begin
                    w_clk_nx[i] = 1'b0;
                end else if (r_cnt[i] == w_half_m1[i]) begin
                    w_clk_nx[i] = 1'b0;
                end else begin
                    w_clk_nx[i] = r_clk_out[i];
                end
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_fiftymhz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]  <= CNT_W'(CLK_HZ);
                r_pdiv[i] <= CNT_W'(CLK_HZ);
                r_cnt[i]  <= LP_ZERO;
            end
            r_mode    <= {NUM_CH{1'b0}};
            r_pmode   <= {NUM_CH{1'b0}};
            r_pend    <= {NUM_CH{1'b0}};
            r_clk_out <= {NUM_CH{1'b1}};
            r_tick    <= {NUM_CH{1'b0}};
            r_cfg_ack <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]  <= w_div_nx[i];
                r_pdiv[i] <= w_pdiv_nx[i];
                r_cnt[i]  <= w_cnt_nx[i];
            end
            r_mode    <= w_mode_nx;
            r_pmode   <= w_pmode_nx;
            r_pend    <= w_pend_nx;
            r_clk_out <= w_clk_nx;
            r_tick    <= w_tick_nx;
            r_cfg_ack <= w_cfg_ok;
            r_cfg_err <= cfg_we && !w_cfg_ok;
        end
    end

endmodule

// File: tb/tb_multi_rate_clk_gen.sv
// Directed bench for multi_rate_clk_gen: a vector table for config/ack/err and two running
// channels, plus hand sequences for default rate, deferred divisor change, sync_clr and reset.
module tb_multi_rate_clk_gen;

    logic clk_fiftymhz = 1'b0;
    always #5 clk_fiftymhz = ~clk_fiftymhz;

    logic       rst, cfg_we, cfg_mode, sync_clr, cfg_ack, cfg_err;
    logic [1:0] cfg_ch;
    logic [4:0] cfg_div;
    logic [3:0] ch_en, clk_out, tick;

    logic       d3_we, d3_mode, d3_sclr, d3_ack, d3_err;
    logic [1:0] d3_ch;
    logic [4:0] d3_div;
    logic [2:0] d3_en, d3_clk, d3_tick;

    int n_checks = 0;
    int n_errors = 0;

    multi_rate_clk_gen #(.CLK_HZ(20), .NUM_CH(4), .CNT_W(5), .CH_W(2)) dut (
        .clk_fiftymhz(clk_fiftymhz), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .ch_en(ch_en), .sync_clr(sync_clr), .clk_out(clk_out), .tick(tick)
    );

    multi_rate_clk_gen #(.CLK_HZ(20), .NUM_CH(3), .CNT_W(5), .CH_W(2)) dut3 (
        .clk_fiftymhz(clk_fiftymhz), .rst(rst), .cfg_we(d3_we), .cfg_ch(d3_ch),
        .cfg_div(d3_div), .cfg_mode(d3_mode), .cfg_ack(d3_ack), .cfg_err(d3_err),
        .ch_en(d3_en), .sync_clr(d3_sclr), .clk_out(d3_clk), .tick(d3_tick)
    );

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [4:0] div;
        logic       mode;
        logic [3:0] en;
        logic       sclr;
        logic [3:0] exp_clk;
        logic [3:0] exp_tick;
        logic       exp_ack;
        logic       exp_err;
    } vec_t;

    vec_t tbl [21];

    // Square clock level m edges into a period of d (high for ceil(d/2)).
    function automatic logic sq(input int m, input int d);
        return (m % d) < ((d + 1) / 2);
    endfunction

    function automatic logic tk(input int m, input int d);
        return (m > 0) && ((m % d) == 0);
    endfunction

    task automatic chk4(input string name, input int idx, input logic [3:0] act,
                        input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: actual %b required %b", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_fiftymhz);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] ch, input logic [4:0] div,
                         input logic mode);
        cfg_we   = we;
        cfg_ch   = ch;
        cfg_div  = div;
        cfg_mode = mode;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd1, 5'd4, 1'b0, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 5'd0, 1'b0, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 2'd2, 5'd5, 1'b0, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1101, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1011, 4'b0010, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1111, 4'b0100, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 2'd2, 5'd1, 1'b0, 4'b0110, 1'b0, 4'b1101, 4'b0000, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1101, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1011, 4'b0010, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1101, 4'b0100, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1101, 4'b0100, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1111, 4'b0110, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 2'd1, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1111, 4'b0100, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1101, 4'b0100, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1101, 4'b0100, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 2'd0, 5'd0, 1'b0, 4'b0110, 1'b0, 4'b1111, 4'b0110, 1'b0, 1'b0};

        rst = 1'b1;
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        ch_en = 4'b0000; sync_clr = 1'b0;
        d3_we = 1'b0; d3_ch = 2'd0; d3_div = 5'd0; d3_mode = 1'b0;
        d3_en = 3'b000; d3_sclr = 1'b0;

        repeat (2) @(posedge clk_fiftymhz);
        #1;
        chk4("reset_clk", 0, clk_out, 4'b1111);
        chk4("reset_tick", 0, tick, 4'b0000);
        chk4("reset_ack_err", 0, {2'b00, cfg_ack, cfg_err}, 4'b0000);
        #3 rst = 1'b0;

        // Default divisor (CLK_HZ = 20) on ch0, others idle.
        ch_en = 4'b0001;
        for (int n = 1; n <= 45; n++) begin
            step();
            chk4("default_clk", n, clk_out, {3'b111, sq(n, 20)});
            chk4("default_tick", n, tick, {3'b000, tk(n, 20)});
        end

        for (int v = 0; v < 21; v++) begin
            drive(tbl[v].we, tbl[v].ch, tbl[v].div, tbl[v].mode);
            ch_en    = tbl[v].en;
            sync_clr = tbl[v].sclr;
            step();
            chk4("tbl_clk", v, clk_out, tbl[v].exp_clk);
            chk4("tbl_tick", v, tick, tbl[v].exp_tick);
            chk4("tbl_ack_err", v, {2'b00, cfg_ack, cfg_err},
                 {2'b00, tbl[v].exp_ack, tbl[v].exp_err});
        end

        // ch3 at D=10; D=3 written at cnt=2 lands at the next wrap; then pulse mode.
        ch_en = 4'b0000;
        drive(1'b1, 2'd3, 5'd10, 1'b0);
        step();
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        step();
        ch_en = 4'b1000;
        for (int n = 1; n <= 28; n++) begin
            logic ec, et;
            if (n == 3) drive(1'b1, 2'd3, 5'd3, 1'b0);
            else if (n == 20) drive(1'b1, 2'd3, 5'd3, 1'b1);
            else drive(1'b0, 2'd0, 5'd0, 1'b0);
            step();
            if (n <= 10) begin
                ec = sq(n, 10); et = tk(n, 10);
            end else if (n <= 22) begin
                ec = sq(n - 10, 3); et = tk(n - 10, 3);
            end else begin
                et = tk(n - 22, 3); ec = et;
            end
            chk4("ch3_clk", n, clk_out, {ec, 3'b111});
            chk4("ch3_tick", n, tick, {et, 3'b000});
            chk4("ch3_ack", n, {3'b000, cfg_ack}, {3'b000, (n == 3) || (n == 20)});
        end
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        ch_en = 4'b0000;
        step();
        chk4("pulse_idle_clk", 0, clk_out, 4'b0111);
        chk4("pulse_idle_tick", 0, tick, 4'b0000);

        // ch1 D=4 and ch2 D=6 started out of phase, then realigned by sync_clr.
        drive(1'b1, 2'd2, 5'd6, 1'b0);
        step();
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        step();
        ch_en = 4'b0010;
        repeat (3) step();
        ch_en = 4'b0110;
        repeat (4) step();
        sync_clr = 1'b1;
        drive(1'b1, 2'd0, 5'd2, 1'b0);
        step();
        chk4("sync_clk", 0, clk_out, 4'b0111);
        chk4("sync_tick", 0, tick, 4'b0000);
        chk4("sync_ack", 0, {3'b000, cfg_ack}, 4'b0001);
        sync_clr = 1'b0;
        drive(1'b0, 2'd0, 5'd0, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            step();
            chk4("resync_clk", n, clk_out, {1'b0, sq(n, 6), sq(n, 4), 1'b1});
            chk4("resync_tick", n, tick, {1'b0, tk(n, 6), tk(n, 4), 1'b0});
        end

        // Asynchronous reset mid-cycle while ticks are high.
        #3 rst = 1'b1;
        #1;
        chk4("async_rst_clk", 0, clk_out, 4'b1111);
        chk4("async_rst_tick", 0, tick, 4'b0000);
        #2 rst = 1'b0;
        ch_en = 4'b0000;

        // Three-channel instance: channel 3 does not exist.
        d3_we = 1'b1; d3_ch = 2'd3; d3_div = 5'd4;
        step();
        chk4("d3_badch", 0, {2'b00, d3_ack, d3_err}, 4'b0001);
        d3_ch = 2'd2; d3_div = 5'd2;
        step();
        chk4("d3_goodch", 0, {2'b00, d3_ack, d3_err}, 4'b0010);
        d3_we = 1'b0;
        step();
        chk4("d3_ack_clear", 0, {2'b00, d3_ack, d3_err}, 4'b0000);
        d3_en = 3'b100;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk4("d3_clk", n, {1'b0, d3_clk}, {1'b0, sq(n, 2), 2'b11});
            chk4("d3_tick", n, {1'b0, d3_tick}, {1'b0, tk(n, 2), 2'b00});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
